// File: rtl/hazard_pipe_ctrl_if.sv
// ============================================================================
// Module      : hazard_pipe_ctrl_if
// Description : Pipeline-control bundle between the decoder/ctrl unit, the
//               ID/EX register and the hazard controller. The slave modport
//               is the controller's view; master is the driving side.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface hazard_pipe_ctrl_if #(
    parameter int CTRL_W = 24,
    parameter int REG_AW = 5
);
    // Decode-stage inputs
    logic [CTRL_W-1:0] id_ctrl;
    logic [REG_AW-1:0] id_rs;
    logic [REG_AW-1:0] id_rt;
    logic              id_uses_rs;
    logic              id_uses_rt;
    // Execute / memory status
    logic              branch_taken;
    logic              mem_req;
    logic              mem_ready;
    // Controller outputs
    logic [CTRL_W-1:0] ex_ctrl;
    logic [REG_AW-1:0] ex_rt;
    logic              pc_write;
    logic              ifid_write;
    logic              ifid_flush;
    logic              mem_hold;
    logic              stall;
    logic              timeout_err;
    logic [31:0]       perf_bubbles;
    logic [31:0]       perf_flushes;
    logic [31:0]       perf_freezes;

    modport slave (
        input  id_ctrl, id_rs, id_rt, id_uses_rs, id_uses_rt,
        input  branch_taken, mem_req, mem_ready,
        output ex_ctrl, ex_rt, pc_write, ifid_write, ifid_flush,
        output mem_hold, stall, timeout_err,
        output perf_bubbles, perf_flushes, perf_freezes
    );

    modport master (
        output id_ctrl, id_rs, id_rt, id_uses_rs, id_uses_rt,
        output branch_taken, mem_req, mem_ready,
        input  ex_ctrl, ex_rt, pc_write, ifid_write, ifid_flush,
        input  mem_hold, stall, timeout_err,
        input  perf_bubbles, perf_flushes, perf_freezes
    );
endinterface

`default_nettype wire

// File: rtl/hazard_pipe_ctrl.sv
// ============================================================================
// Module      : hazard_pipe_ctrl
// Description : Owns the ID/EX control register. Inserts a single bubble on a
//               load-use hazard, squashes IF/ID and ID/EX on a taken branch,
//               and freezes the pipeline while a data-memory access is
//               pending, with a timeout watchdog (RUN/FREEZE/ERR).
//               Optional macro HAZARD_PERF_EN enables saturating 32-bit
//               bubble/flush/freeze counters; otherwise they read as zero.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module hazard_pipe_ctrl #(
    parameter int CTRL_W      = 24,
    parameter int MEMREAD_LSB = 6,
    parameter int REG_AW      = 5,
    parameter int MEM_TIMEOUT = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    hazard_pipe_ctrl_if.slave bus
);

    // A zero timeout still needs a legal (unused) one-bit counter
    localparam int WCNT_W = (MEM_TIMEOUT == 0) ? 1 : $clog2(MEM_TIMEOUT + 1);
    localparam logic [WCNT_W-1:0] C_WAIT_LIMIT =
        WCNT_W'((MEM_TIMEOUT == 0) ? 0 : MEM_TIMEOUT - 1);

    typedef enum logic [1:0] {
        ST_RUN    = 2'd0,
        ST_FREEZE = 2'd1,
        ST_ERR    = 2'd2
    } state_t;

    state_t            r_state, w_state_next;
    logic [WCNT_W-1:0] r_wait_cnt, w_wait_cnt_next;
    logic [CTRL_W-1:0] r_ex_ctrl;
    logic [REG_AW-1:0] r_ex_rt;

    logic w_ex_load, w_loaduse, w_mem_wait, w_freeze;
    logic w_pc_write, w_ifid_write, w_ifid_flush, w_mem_hold, w_stall;

    assign w_ex_load  = (r_ex_ctrl[MEMREAD_LSB+1:MEMREAD_LSB] != 2'b00);
    assign w_loaduse  = w_ex_load && (r_ex_rt != '0) &&
                        ((bus.id_uses_rs && (bus.id_rs == r_ex_rt)) ||
                         (bus.id_uses_rt && (bus.id_rt == r_ex_rt)));
    assign w_mem_wait = bus.mem_req && !bus.mem_ready;
    assign w_freeze   = (r_state == ST_ERR) || w_mem_wait;

    // Watchdog state register and freeze-cycle counter
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state    <= ST_RUN;
            r_wait_cnt <= '0;
        end else begin
            r_state    <= w_state_next;
            r_wait_cnt <= w_wait_cnt_next;
        end
    end

    // Next-state logic and prioritised pipeline enables (freeze > flush > load-use)
    always_comb begin
        w_state_next    = r_state;
        w_wait_cnt_next = r_wait_cnt;
        w_pc_write      = 1'b0;
        w_ifid_write    = 1'b0;
        w_ifid_flush    = 1'b0;
        w_mem_hold      = 1'b0;
        w_stall         = 1'b0;

        case (r_state)
            ST_RUN: begin
                if (w_mem_wait) w_state_next = ST_FREEZE;
            end
            ST_FREEZE: begin
                if (bus.mem_ready)
                    w_state_next = ST_RUN;
                else if ((MEM_TIMEOUT != 0) && (r_wait_cnt == C_WAIT_LIMIT))
                    w_state_next = ST_ERR;
            end
            ST_ERR:  w_state_next = ST_ERR;
            default: w_state_next = ST_RUN;
        endcase

        // Counter only advances on memory-caused freeze; any return to RUN clears it
        if (w_state_next == ST_RUN)
            w_wait_cnt_next = '0;
        else if (w_mem_wait && (r_state != ST_ERR))
            w_wait_cnt_next = r_wait_cnt + 1'b1;

        if (rst_n) begin
            if (w_freeze) begin
                w_mem_hold = 1'b1;
                w_stall    = 1'b1;
            end else if (bus.branch_taken) begin
                w_pc_write   = 1'b1;
                w_ifid_write = 1'b1;
                w_ifid_flush = 1'b1;
            end else if (w_loaduse) begin
                w_stall = 1'b1;
            end else begin
                w_pc_write   = 1'b1;
                w_ifid_write = 1'b1;
            end
        end
    end

    // ID/EX control register: hold on freeze, zero on flush or bubble
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_ex_ctrl <= '0;
            r_ex_rt   <= '0;
        end else if (w_freeze) begin
            r_ex_ctrl <= r_ex_ctrl;
            r_ex_rt   <= r_ex_rt;
        end else if (bus.branch_taken || w_loaduse) begin
            r_ex_ctrl <= '0;
            r_ex_rt   <= '0;
        end else begin
            r_ex_ctrl <= bus.id_ctrl;
            r_ex_rt   <= bus.id_rt;
        end
    end

    assign bus.ex_ctrl     = r_ex_ctrl;
    assign bus.ex_rt       = r_ex_rt;
    assign bus.pc_write    = w_pc_write;
    assign bus.ifid_write  = w_ifid_write;
    assign bus.ifid_flush  = w_ifid_flush;
    assign bus.mem_hold    = w_mem_hold;
    assign bus.stall       = w_stall;
    assign bus.timeout_err = (r_state == ST_ERR);

`ifdef HAZARD_PERF_EN
    logic [31:0] r_perf_bubbles, r_perf_flushes, r_perf_freezes;
    logic        w_ev_bubble, w_ev_flush;

    assign w_ev_bubble = !w_freeze && !bus.branch_taken && w_loaduse;
    assign w_ev_flush  = !w_freeze && bus.branch_taken;

    // Saturating event counters
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_perf_bubbles <= '0;
            r_perf_flushes <= '0;
            r_perf_freezes <= '0;
        end else begin
            if (w_ev_bubble && (r_perf_bubbles != 32'hFFFF_FFFF))
                r_perf_bubbles <= r_perf_bubbles + 32'd1;
            if (w_ev_flush && (r_perf_flushes != 32'hFFFF_FFFF))
                r_perf_flushes <= r_perf_flushes + 32'd1;
            if (w_freeze && (r_perf_freezes != 32'hFFFF_FFFF))
                r_perf_freezes <= r_perf_freezes + 32'd1;
        end
    end

    assign bus.perf_bubbles = r_perf_bubbles;
    assign bus.perf_flushes = r_perf_flushes;
    assign bus.perf_freezes = r_perf_freezes;
`else
    assign bus.perf_bubbles = 32'd0;
    assign bus.perf_flushes = 32'd0;
    assign bus.perf_freezes = 32'd0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_hazard_pipe_ctrl.sv
// ============================================================================
// Module      : tb_hazard_pipe_ctrl
// Description : Directed self-checking bench for hazard_pipe_ctrl
//               (MEM_TIMEOUT=4). Perf expectations follow HAZARD_PERF_EN.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_hazard_pipe_ctrl;

    localparam int CTRL_W = 24;
    localparam int REG_AW = 5;

`ifdef HAZARD_PERF_EN
    localparam int PERF = 1;
`else
    localparam int PERF = 0;
`endif

    logic clk = 1'b0;
    logic rst_n;
    int   n_tests = 0;
    int   n_fail  = 0;

    always #5 clk = ~clk;

    hazard_pipe_ctrl_if #(.CTRL_W(CTRL_W), .REG_AW(REG_AW)) bus ();

    hazard_pipe_ctrl #(
        .CTRL_W(CTRL_W), .MEMREAD_LSB(6), .REG_AW(REG_AW), .MEM_TIMEOUT(4)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .bus(bus)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Wait until just after the next rising edge has been absorbed
    task automatic cyc();
        @(negedge clk);
    endtask

    initial begin
        rst_n = 1'b0;
        bus.id_ctrl = '0; bus.id_rs = '0; bus.id_rt = '0;
        bus.id_uses_rs = 1'b0; bus.id_uses_rt = 1'b0;
        bus.branch_taken = 1'b0; bus.mem_req = 1'b0; bus.mem_ready = 1'b0;

        // Reset state
        cyc(); cyc();
        chk("rst_pc_write", 32'(bus.pc_write), 0);
        chk("rst_stall", 32'(bus.stall), 0);
        chk("rst_ex_ctrl", 32'(bus.ex_ctrl), 0);
        chk("rst_ex_rt", 32'(bus.ex_rt), 0);
        chk("rst_timeout", 32'(bus.timeout_err), 0);

        // Normal: a load into EX (MemRead=01, rt=8)
        rst_n = 1'b1;
        bus.id_ctrl = 24'h000040; bus.id_rt = 5'd8; bus.id_rs = 5'd3;
        bus.id_uses_rs = 1'b1; bus.id_uses_rt = 1'b1;
        #1;
        chk("norm_pc_write", 32'(bus.pc_write), 1);
        chk("norm_ifid_write", 32'(bus.ifid_write), 1);
        cyc();
        chk("norm_ex_ctrl", 32'(bus.ex_ctrl), 32'h40);
        chk("norm_ex_rt", 32'(bus.ex_rt), 8);

        // Load-use on rs=8
        bus.id_ctrl = 24'h001234; bus.id_rs = 5'd8; bus.id_rt = 5'd2;
        #1;
        chk("lu_pc_write", 32'(bus.pc_write), 0);
        chk("lu_ifid_write", 32'(bus.ifid_write), 0);
        chk("lu_stall", 32'(bus.stall), 1);
        cyc();
        chk("lu_bubble_ctrl", 32'(bus.ex_ctrl), 0);
        chk("lu_bubble_rt", 32'(bus.ex_rt), 0);
        #1;
        chk("lu_selfclear_stall", 32'(bus.stall), 0);
        chk("lu_selfclear_pc", 32'(bus.pc_write), 1);
        cyc();
        chk("lu_resume_ctrl", 32'(bus.ex_ctrl), 32'h1234);
        chk("lu_perf_bubbles", bus.perf_bubbles, PERF);

        // Register $0 never hazards
        bus.id_ctrl = 24'h0000C0; bus.id_rt = 5'd0; bus.id_rs = 5'd1;
        cyc();
        chk("r0_ex_ctrl", 32'(bus.ex_ctrl), 32'hC0);
        bus.id_ctrl = 24'h000101; bus.id_rs = 5'd0; bus.id_rt = 5'd0;
        #1;
        chk("r0_stall", 32'(bus.stall), 0);
        chk("r0_pc_write", 32'(bus.pc_write), 1);
        cyc();
        chk("r0_next_ctrl", 32'(bus.ex_ctrl), 32'h101);

        // Branch coincident with load-use: flush wins
        bus.id_ctrl = 24'h000040; bus.id_rt = 5'd9; bus.id_rs = 5'd1;
        cyc();
        bus.id_ctrl = 24'h000222; bus.id_rs = 5'd9; bus.id_rt = 5'd1;
        bus.branch_taken = 1'b1;
        #1;
        chk("br_ifid_flush", 32'(bus.ifid_flush), 1);
        chk("br_pc_write", 32'(bus.pc_write), 1);
        chk("br_stall", 32'(bus.stall), 0);
        cyc();
        bus.branch_taken = 1'b0;
        chk("br_ex_ctrl", 32'(bus.ex_ctrl), 0);
        chk("br_perf_bubbles", bus.perf_bubbles, PERF);
        chk("br_perf_flushes", bus.perf_flushes, PERF);

        // Memory freeze for 3 cycles with a branch that must be ignored
        bus.id_ctrl = 24'h000A3C; bus.id_rt = 5'd4; bus.id_rs = 5'd5;
        cyc();
        chk("fz_pre_ctrl", 32'(bus.ex_ctrl), 32'hA3C);
        bus.id_ctrl = 24'h000111; bus.mem_req = 1'b1; bus.mem_ready = 1'b0;
        bus.branch_taken = 1'b1;
        for (int i = 0; i < 3; i++) begin
            #1;
            chk("fz_mem_hold", 32'(bus.mem_hold), 1);
            chk("fz_no_flush", 32'(bus.ifid_flush), 0);
            chk("fz_pc_write", 32'(bus.pc_write), 0);
            cyc();
            chk("fz_ex_held", 32'(bus.ex_ctrl), 32'hA3C);
        end
        bus.branch_taken = 1'b0; bus.mem_ready = 1'b1;
        #1;
        chk("fz_release_hold", 32'(bus.mem_hold), 0);
        chk("fz_release_pc", 32'(bus.pc_write), 1);
        cyc();
        bus.mem_req = 1'b0; bus.mem_ready = 1'b0;
        chk("fz_after_ctrl", 32'(bus.ex_ctrl), 32'h111);
        chk("fz_timeout", 32'(bus.timeout_err), 0);
        chk("fz_perf_freezes", bus.perf_freezes, 3 * PERF);

        // Watchdog: 4 unanswered freeze cycles lead to ERR
        bus.mem_req = 1'b1; bus.mem_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            #1;
            chk("wd_pre_timeout", 32'(bus.timeout_err), 0);
            cyc();
        end
        chk("wd_timeout", 32'(bus.timeout_err), 1);
        bus.mem_ready = 1'b1;
        #1;
        chk("wd_err_hold", 32'(bus.mem_hold), 1);
        chk("wd_err_stall", 32'(bus.stall), 1);
        cyc();
        bus.mem_req = 1'b0;
        cyc();
        chk("wd_sticky", 32'(bus.timeout_err), 1);
        chk("wd_sticky_pc", 32'(bus.pc_write), 0);

        // Reset out of ERR
        rst_n = 1'b0;
        #1;
        chk("wdrst_pc_write", 32'(bus.pc_write), 0);
        chk("wdrst_mem_hold", 32'(bus.mem_hold), 0);
        chk("wdrst_stall", 32'(bus.stall), 0);
        cyc();
        chk("wdrst_timeout", 32'(bus.timeout_err), 0);
        rst_n = 1'b1; bus.mem_ready = 1'b0;
        #1;
        chk("wdrst_run_pc", 32'(bus.pc_write), 1);
        chk("wdrst_run_hold", 32'(bus.mem_hold), 0);

        // Reset mid-operation with a populated ID/EX register
        bus.id_ctrl = 24'hABCDEF; bus.id_rt = 5'd7; bus.id_rs = 5'd1;
        cyc();
        chk("mrst_pre_ctrl", 32'(bus.ex_ctrl), 32'hABCDEF);
        bus.id_ctrl = 24'h000000; bus.id_rt = 5'd2;
        rst_n = 1'b0;
        cyc();
        chk("mrst_ex_ctrl", 32'(bus.ex_ctrl), 0);
        chk("mrst_ex_rt", 32'(bus.ex_rt), 0);
        chk("mrst_perf_b", bus.perf_bubbles, 0);
        chk("mrst_perf_f", bus.perf_flushes, 0);
        chk("mrst_perf_z", bus.perf_freezes, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
